// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_e        : controller FSM encoding
//   OP_ADD/OP_SUB  : values of op_sub selecting the operation
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder built from two half adders and an OR gate.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out (majority of the three inputs)
module full_adder_bit (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (
      .a_i (a_i),
      .b_i (b_i),
      .s_o (s1),
      .c_o (c1)
   );

   half_adder u_ha1 (
      .a_i (s1),
      .b_i (c_i),
      .s_o (s_o),
      .c_o (c2)
   );

   // The two partial carries can never both be set, so OR equals majority.
   assign c_o = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder.
//   a_i, b_i : operand bits
//   s_o      : sum bit
//   c_o      : carry bit
module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. One full-adder cell is stepped over
// WIDTH cycles, LSB first, to build a WIDTH-bit result plus carry-out and
// signed overflow.
//
//   state | meaning
//   IDLE  | ready for operands (in_ready = 1)
//   RUN   | one result bit per cycle, counter tracks bit position
//   DONE  | result held on out_valid until out_ready
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (op_sub, a, b)
//   out_valid/out_ready : result handshake (sum, c_out, ovf)
//   busy                : high in RUN or DONE
module serial_adder_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic             fa_s;
   logic             fa_c;

   full_adder_bit u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         c_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Subtract is A + ~B + 1: invert B and seed the carry.
                  a_q        <= a;
                  b_q        <= (op_sub == OP_SUB) ? ~b : b;
                  carry_q    <= (op_sub == OP_SUB);
                  cnt_q      <= '0;
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
               a_q     <= {1'b0, a_q[WIDTH-1:1]};
               b_q     <= {1'b0, b_q[WIDTH-1:1]};
               carry_q <= fa_c;
               if (cnt_q == LAST_BIT) begin
                  // carry_q is the carry entering the MSB here.
                  c_out_q     <= fa_c;
                  ovf_q       <= carry_q ^ fa_c;
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance for directed cases and a
// 32-bit instance for a long add/sub stream against a reference sum.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        in_valid8, op8, out_ready8;
   logic [7:0]  a8, b8;
   logic        in_ready8, out_valid8, c8, ovf8, busy8;
   logic [7:0]  sum8;

   logic        in_valid32, op32, out_ready32;
   logic [31:0] a32, b32;
   logic        in_ready32, out_valid32, c32, ovf32, busy32;
   logic [31:0] sum32;

   int n_cmp = 0;
   int n_err = 0;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .op_sub    (op8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .c_out     (c8),
      .ovf       (ovf8),
      .busy      (busy8)
   );

   serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .op_sub    (op32),
      .a         (a32),
      .b         (b32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .sum       (sum32),
      .c_out     (c32),
      .ovf       (ovf32),
      .busy      (busy32)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one 8-bit operation and wait for out_valid; returns result and
   // the number of edges from the accept edge to out_valid (-1 on timeout).
   task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] s, output logic c, output logic v,
                       output int lat);
      int k;
      k = 0;
      while (!in_ready8 && k < 100) begin
         step();
         k++;
      end
      op8 = op; a8 = a; b8 = b; in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = ~op;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (out_valid8) begin
            lat = i;
            break;
         end
      end
      s = sum8; c = c8; v = ovf8;
   endtask

   task automatic release8();
      out_ready8 = 1'b1;
      step();
      out_ready8 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL reset in_ready8: got %b want 1", in_ready8); end
      n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset out_valid8: got %b want 0", out_valid8); end
      n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset busy8: got %b want 0", busy8); end
      n_cmp++; if ({sum8, c8, ovf8} !== 10'h0) begin n_err++; $display("FAIL reset result8: got %h/%b/%b want 00/0/0", sum8, c8, ovf8); end
      n_cmp++; if ({in_ready32, out_valid32, busy32} !== 3'b100) begin n_err++; $display("FAIL reset flags32: got %b want 100", {in_ready32, out_valid32, busy32}); end
      n_cmp++; if ({sum32, c32, ovf32} !== 34'h0) begin n_err++; $display("FAIL reset result32: got %h/%b/%b want 0/0/0", sum32, c32, ovf32); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add();
      logic [7:0] s; logic c, v; int lat;
      run8(1'b0, 8'h0F, 8'h01, s, c, v, lat);
      n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL add_0f_01 latency: got %0d want 8", lat); end
      n_cmp++; if ({s, c, v} !== {8'h10, 1'b0, 1'b0}) begin n_err++; $display("FAIL add_0f_01 result: got %h/%b/%b want 10/0/0", s, c, v); end
      n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL add_0f_01 busy in DONE: got %b want 1", busy8); end
      release8();
      n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL add_0f_01 in_ready after handshake: got %b want 1", in_ready8); end
      run8(1'b0, 8'hFF, 8'h01, s, c, v, lat);
      n_cmp++; if ({s, c, v} !== {8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL add_ff_01 result: got %h/%b/%b want 00/1/0", s, c, v); end
      release8();
      run8(1'b0, 8'h7F, 8'h01, s, c, v, lat);
      n_cmp++; if ({s, c, v} !== {8'h80, 1'b0, 1'b1}) begin n_err++; $display("FAIL add_7f_01 result: got %h/%b/%b want 80/0/1", s, c, v); end
      release8();
   endtask

   task automatic test_sub();
      logic [7:0] s; logic c, v; int lat;
      run8(1'b1, 8'h05, 8'h07, s, c, v, lat);
      n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL sub_05_07 latency: got %0d want 8", lat); end
      n_cmp++; if ({s, c, v} !== {8'hFE, 1'b0, 1'b0}) begin n_err++; $display("FAIL sub_05_07 result: got %h/%b/%b want fe/0/0", s, c, v); end
      release8();
      run8(1'b1, 8'h80, 8'h01, s, c, v, lat);
      n_cmp++; if ({s, c, v} !== {8'h7F, 1'b1, 1'b1}) begin n_err++; $display("FAIL sub_80_01 result: got %h/%b/%b want 7f/1/1", s, c, v); end
      release8();
      run8(1'b1, 8'h3C, 8'h3C, s, c, v, lat);
      n_cmp++; if ({s, c, v} !== {8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL sub_3c_3c result: got %h/%b/%b want 00/1/0", s, c, v); end
      release8();
   endtask

   task automatic test_backpressure();
      logic [7:0] s; logic c, v; int lat; int bad;
      run8(1'b0, 8'h33, 8'h11, s, c, v, lat);
      n_cmp++; if ({s, c, v} !== {8'h44, 1'b0, 1'b0}) begin n_err++; $display("FAIL bp result: got %h/%b/%b want 44/0/0", s, c, v); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid8 = i[0]; a8 = 8'($urandom); b8 = 8'($urandom); op8 = i[1];
         step();
         n_cmp++;
         if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || sum8 !== 8'h44 || c8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_err++;
            $display("FAIL bp hold cycle %0d: got rdy=%b vld=%b sum=%h c=%b v=%b want 0/1/44/0/0",
                     i, in_ready8, out_valid8, sum8, c8, ovf8);
         end
      end
      // Handshake with in_valid high: must complete without accepting.
      in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01; op8 = 1'b0;
      release8();
      n_cmp++; if ({in_ready8, out_valid8, busy8} !== 3'b100) begin n_err++; $display("FAIL bp release flags: got %b want 100", {in_ready8, out_valid8, busy8}); end
      n_cmp++; if (sum8 !== 8'h44) begin n_err++; $display("FAIL bp sum held in IDLE: got %h want 44", sum8); end
      // The still-high in_valid is taken on the following IDLE edge.
      step();
      in_valid8 = 1'b0;
      n_cmp++; if ({in_ready8, busy8} !== 2'b01) begin n_err++; $display("FAIL bp accept after IDLE: got %b want 01", {in_ready8, busy8}); end
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (out_valid8) begin lat = i; break; end
      end
      n_cmp++; if (lat !== 8 || sum8 !== 8'h02) begin n_err++; $display("FAIL bp queued op: got lat=%0d sum=%h want 8/02", lat, sum8); end
      release8();
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] s; logic c, v; int lat;
      op8 = 1'b0; a8 = 8'h5A; b8 = 8'h33; in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      step(); step(); step();
      n_cmp++; if (busy8 !== 1'b1 || out_valid8 !== 1'b0) begin n_err++; $display("FAIL mid_rst running: got busy=%b vld=%b want 1/0", busy8, out_valid8); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_cmp++; if ({in_ready8, out_valid8, busy8} !== 3'b100) begin n_err++; $display("FAIL mid_rst flags: got %b want 100", {in_ready8, out_valid8, busy8}); end
      n_cmp++; if ({sum8, c8, ovf8} !== 10'h0) begin n_err++; $display("FAIL mid_rst result: got %h/%b/%b want 00/0/0", sum8, c8, ovf8); end
      run8(1'b0, 8'h01, 8'h02, s, c, v, lat);
      n_cmp++; if (lat !== 8 || {s, c, v} !== {8'h03, 1'b0, 1'b0}) begin n_err++; $display("FAIL mid_rst follow-up: got lat=%0d %h/%b/%b want 8 03/0/0", lat, s, c, v); end
      release8();
   endtask

   task automatic test_random_stream();
      logic [31:0] ra, rb, bb;
      logic        rop, exp_v;
      logic [32:0] full;
      int          lat, k;
      for (int n = 0; n < 1000; n++) begin
         rop = 1'($urandom_range(0, 1));
         ra = $urandom; rb = $urandom;
         if (n == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h1; rop = 1'b0; end
         if (n == 1) begin ra = 32'h8000_0000; rb = 32'h1; rop = 1'b1; end
         bb = rop ? ~rb : rb;
         full = {1'b0, ra} + {1'b0, bb} + {32'h0, rop};
         exp_v = (ra[31] == bb[31]) && (full[31] != ra[31]);
         k = 0;
         while (!in_ready32 && k < 100) begin step(); k++; end
         op32 = rop; a32 = ra; b32 = rb; in_valid32 = 1'b1;
         step();
         in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom;
         lat = -1;
         for (int i = 1; i <= 200; i++) begin
            step();
            if (out_valid32) begin lat = i; break; end
         end
         n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL rnd[%0d] latency: got %0d want 32", n, lat); end
         n_cmp++; if ({c32, sum32} !== full) begin n_err++; $display("FAIL rnd[%0d] op=%b a=%h b=%h {c,sum}: got %b/%h want %b/%h", n, rop, ra, rb, c32, sum32, full[32], full[31:0]); end
         n_cmp++; if (ovf32 !== exp_v) begin n_err++; $display("FAIL rnd[%0d] op=%b a=%h b=%h ovf: got %b want %b", n, rop, ra, rb, ovf32, exp_v); end
         k = 0;
         while (out_valid32 && k < 50) begin
            out_ready32 = 1'($urandom_range(0, 1));
            step();
            k++;
         end
         if (out_valid32) begin
            out_ready32 = 1'b1;
            step();
         end
         out_ready32 = 1'b0;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
      in_valid32 = 1'b0; op32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_op();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
